sum_req_initiator: RTL
======================

// Module: sum_req_initiator
// PURPOSE
//  Initiator side of the start/valid sum protocol: buffers operand pairs from an upstream
//  producer, issues them one at a time to a sum responder (start/a/b), waits for valid/y,
//  and returns each result (or a timeout error) upstream. Sits between a request source
//  and any single-cycle-latency start/valid datapath.
// PARAMETERS
//  W        16  operand/result width
//  DEPTH     4  request FIFO entries (power of 2, >=2)
//  TIMEOUT   4  max edges in WAIT without valid before error (>=1)
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        reset, asynchronous, active-low
//  req_valid    in   1        upstream operand pair offered
//  req_ready    out  1        FIFO can accept (= !full)
//  req_a        in   W        operand a
//  req_b        in   W        operand b
//  start        out  1        one-cycle issue strobe to responder
//  a            out  W        operand a to responder (held from ISSUE through WAIT)
//  b            out  W        operand b to responder (held from ISSUE through WAIT)
//  y            in   W        responder result
//  valid        in   1        responder result valid
//  rsp_valid    out  1        one-cycle result/err strobe upstream
//  rsp_sum      out  W        captured y (0 on timeout)
//  rsp_err      out  1        with rsp_valid: 1 = timeout, no valid received
//  spurious_err out  1        sticky: valid seen outside WAIT
//  busy         out  1        FIFO non-empty or state != IDLE
// BEHAVIOUR
//  Reset (async): FIFO emptied, state=IDLE, start=0, a=b=0, rsp_valid=0, rsp_sum=0,
//   rsp_err=0, spurious_err=0, wait cnt=0. Mid-operation reset drops all queued/in-flight reqs.
//  FIFO: push on req_valid&&req_ready; full blocks push even if pop same edge; push+pop
//   same edge on non-full non-empty FIFO keeps count; pointers wrap mod DEPTH.
//  FSM (registered state; start = state==ISSUE):
//   IDLE : FIFO non-empty -> ISSUE, load a/b from head. Else stay.
//   ISSUE: start=1 exactly one cycle -> WAIT, cnt=0.
//   WAIT : valid sampled -> rsp_valid=1, rsp_sum=y, rsp_err=0, pop, -> IDLE.
//          else cnt+1; cnt reaching TIMEOUT -> rsp_valid=1, rsp_err=1, rsp_sum=0, pop, -> IDLE.
//  Timing: push at edge E0 -> start high E1..E2 -> responder valid E2..E3 -> rsp_valid
//   high E3..E4. Min 1 IDLE cycle between starts: peak rate 1 request per 3 cycles.
//  start never high on consecutive cycles; a/b stable while start or WAIT.
//  rsp_valid/rsp_err are single-cycle pulses; rsp_sum holds until next rsp_valid.
//  valid in IDLE/ISSUE sets spurious_err (sticky until reset), otherwise ignored.
//  Arithmetic none here; y captured at full W, no modification.
// TESTING
//  1 Reset: rst_n=0 mid-WAIT with 3 queued -> start=0, rsp_valid=0, busy=0 immediately;
//    req_ready=1 after release.
//  2 Single op: push a=5,b=7, model responder -> start 1 cycle after push; rsp_valid 2 cycles
//    after start with rsp_sum=12, rsp_err=0.
//  3 Back-to-back: push 4 pairs consecutive cycles -> req_ready stays 1; 5th push while
//    full -> req_ready=0; results return in order, starts spaced exactly 3 cycles.
//  4 Timeout: responder never asserts valid, TIMEOUT=4 -> rsp_valid=1, rsp_err=1,
//    rsp_sum=0 exactly 4 edges after start sampled; next request then issues normally.
//  5 Spurious: drive valid=1 while IDLE -> spurious_err=1, stays 1 through later normal ops.
//  6 Wrap: 2*DEPTH+1 requests (a=i,b=2i) -> all rsp_sum=3i, in order, no loss/dup.

Source files
------------

// File: rtl/sum_req_initiator.sv
// sum_req_initiator: buffers upstream operand pairs in a small FIFO, issues them one at a
// time to a single-cycle start/valid sum responder and returns each result (or a timeout
// error) upstream as a one-cycle strobe.
module sum_req_initiator #(
    parameter int unsigned W       = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         start,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    input  logic [W-1:0] y,
    input  logic         valid,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_err,
    output logic         spurious_err,
    output logic         busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    mem_a_q [DEPTH];
    logic [W-1:0]    mem_b_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [W-1:0]    rsp_sum_q, rsp_sum_d;
    logic            spur_q, spur_d;
    logic            full, empty, push, pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign req_ready = !full;
    // A full FIFO refuses the push even when the head pops on the same edge.
    assign push      = req_valid && !full;

    // FIFO storage; no reset needed, occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= req_a;
            mem_b_q[wr_ptr_q] <= req_b;
        end
    end

    // FIFO occupancy update.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FSM next state; the head entry stays in the FIFO until its response is returned.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_sum_d   = rsp_sum_q;
        pop         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = StIssue;
                    a_d     = mem_a_q[rd_ptr_q];
                    b_d     = mem_b_q[rd_ptr_q];
                end
            end
            StIssue: begin
                state_d = StWait;
                cnt_d   = '0;
            end
            StWait: begin
                if (valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_sum_d   = y;
                    pop         = 1'b1;
                    state_d     = StIdle;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_sum_d   = '0;
                    pop         = 1'b1;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A valid outside WAIT is a protocol violation; remember it until reset.
    assign spur_d = spur_q | (valid && (state_q != StWait));

    // State, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_sum_q   <= '0;
            spur_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_sum_q   <= rsp_sum_d;
            spur_q      <= spur_d;
        end
    end

    assign start        = (state_q == StIssue);
    assign a            = a_q;
    assign b            = b_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_sum      = rsp_sum_q;
    assign rsp_err      = rsp_err_q;
    assign spurious_err = spur_q;
    assign busy         = !empty || (state_q != StIdle);

endmodule
